hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline. It drives the flush inputs of the ID/EXE register, and the freeze/flush controls of PC, IF/ID and EXE/MEM.
- Detects three conditions:
  - load-use hazards against the instruction in ID;
  - RAW hazards when forwarding is disabled;
  - multi-cycle data-memory waits.
- Applies taken-branch flushes. Tracks stall statistics and a memory-timeout error.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl_hazard_detect.sv | 31 +++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM encoding, the hard-wired zero register, and the register-match helper.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a writing stage targets a register the ID instruction reads.
  function automatic logic dest_hit(
    input logic [4:0] dest,
    input logic       wb_en,
    input logic [4:0] src1,
    input logic [4:0] src2,
    input logic       two_src
  );
    return wb_en && (dest != REG_ZERO) &&
           ((dest == src1) || (two_src && (dest == src2)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side connection bundle of hazard_ctrl: hazard sources in,
// stall/flush controls and status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             fwd_en;
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_two_src;
  logic [4:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [4:0]       mem_dest;
  logic             mem_wb_en;
  logic             br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_freeze;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_exe_flush;
  logic             exe_mem_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fwd_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en,
           exe_mem_read, mem_dest, mem_wb_en, br_taken, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
           exe_mem_freeze, mem_timeout, stall_cnt
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en,
           exe_mem_read, mem_dest, mem_wb_en, br_taken, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
           exe_mem_freeze, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// Combinational RAW compare of the ID sources against EXE and MEM destinations.
// With forwarding on, only a load in EXE still has to stall.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       fwd_en,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic       id_two_src,
  input  logic [4:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_read,
  input  logic [4:0] mem_dest,
  input  logic       mem_wb_en,
  output logic       hz_exe,
  output logic       hz_mem,
  output logic       data_hz
);

  // Per-stage match and the forwarding-dependent stall decision.
  always_comb begin
    hz_exe = dest_hit(exe_dest, exe_wb_en, id_src1, id_src2, id_two_src);
    hz_mem = dest_hit(mem_dest, mem_wb_en, id_src1, id_src2, id_two_src);
    if (fwd_en) begin
      data_hz = hz_exe && exe_mem_read;
    end else begin
      data_hz = hz_exe || hz_mem;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller: memory-wait freeze, taken-branch flush,
// data-hazard bubble, plus a sticky memory timeout and saturating stall count.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  hz_state_e        state_r;
  logic [WC_W-1:0]  wait_cnt_r;
  logic [WC_W-1:0]  wait_inc_s;
  logic             mem_timeout_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             hz_exe_s;
  logic             hz_mem_s;
  logic             data_hz_s;
  logic             mem_stall_s;
  logic             pc_freeze_s;
  logic             if_id_freeze_s;
  logic             if_id_flush_s;
  logic             id_exe_flush_s;
  logic             exe_mem_freeze_s;

  hazard_detect u_detect (
    .fwd_en       (bus.fwd_en),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .id_two_src   (bus.id_two_src),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_read (bus.exe_mem_read),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hz_exe       (hz_exe_s),
    .hz_mem       (hz_mem_s),
    .data_hz      (data_hz_s)
  );

  // Prioritised zero-latency controls; a memory wait masks the branch,
  // which is re-presented once the pipeline is released.
  always_comb begin
    pc_freeze_s      = 1'b0;
    if_id_freeze_s   = 1'b0;
    if_id_flush_s    = 1'b0;
    id_exe_flush_s   = 1'b0;
    exe_mem_freeze_s = 1'b0;
    mem_stall_s      = ((state_r == MEM_WAIT) || bus.mem_req) && !bus.mem_ready;
    if (!rst) begin
      pc_freeze_s = 1'b0;
    end else if (mem_stall_s) begin
      pc_freeze_s      = 1'b1;
      if_id_freeze_s   = 1'b1;
      exe_mem_freeze_s = 1'b1;
    end else if (bus.br_taken) begin
      if_id_flush_s  = 1'b1;
      id_exe_flush_s = 1'b1;
    end else if (data_hz_s) begin
      pc_freeze_s    = 1'b1;
      if_id_freeze_s = 1'b1;
      id_exe_flush_s = 1'b1;
    end else begin
      pc_freeze_s = 1'b0;
    end
  end

  assign wait_inc_s = wait_cnt_r + {{(WC_W-1){1'b0}}, 1'b1};

  // Wait FSM, timeout detection and stall statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
      stall_cnt_r   <= '0;
    end else begin
      case (state_r)
        RUN: begin
          wait_cnt_r <= '0;
          if (bus.mem_req && !bus.mem_ready) begin
            state_r <= MEM_WAIT;
          end else begin
            state_r <= RUN;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state_r    <= RUN;
            wait_cnt_r <= '0;
          end else begin
            // The entry cycle in RUN is the first wait cycle, so reaching
            // TIMEOUT-1 here means TIMEOUT stalled cycles have elapsed.
            if (wait_cnt_r != WC_W'(TIMEOUT)) begin
              wait_cnt_r <= wait_inc_s;
            end else begin
              wait_cnt_r <= wait_cnt_r;
            end
            if ((wait_cnt_r != WC_W'(TIMEOUT)) && (wait_inc_s == WC_W'(TIMEOUT - 1))) begin
              mem_timeout_r <= 1'b1;
            end else begin
              mem_timeout_r <= mem_timeout_r;
            end
          end
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= '0;
        end
      endcase
      if (pc_freeze_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.pc_freeze      = pc_freeze_s;
  assign bus.if_id_freeze   = if_id_freeze_s;
  assign bus.if_id_flush    = if_id_flush_s;
  assign bus.id_exe_flush   = id_exe_flush_s;
  assign bus.exe_mem_freeze = exe_mem_freeze_s;
  assign bus.mem_timeout    = mem_timeout_r;
  assign bus.stall_cnt      = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4 and a 3-bit stall counter.
module tb_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  // ctl order: {pc_freeze, if_id_freeze, if_id_flush, id_exe_flush, exe_mem_freeze}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_HAZ  = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_MEM  = 5'b11001;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [4:0] ctl = {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush,
                    bus.id_exe_flush, bus.exe_mem_freeze};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fwd_en       = 1'b1;
    bus.id_src1      = 5'd0;
    bus.id_src2      = 5'd0;
    bus.id_two_src   = 1'b0;
    bus.exe_dest     = 5'd0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_read = 1'b0;
    bus.mem_dest     = 5'd0;
    bus.mem_wb_en    = 1'b0;
    bus.br_taken     = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    bus.mem_req = 1'b1;
    bus.fwd_en = 1'b0; bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd3; bus.id_src1 = 5'd3;
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL reset_forced ctl=%b exp=%b", ctl, C_NONE); end
    tick();
    total++;
    if (bus.stall_cnt !== 3'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    total++;
    if (bus.mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", bus.mem_timeout); end
    clear_inputs();
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL reset_idle ctl=%b exp=%b", ctl, C_NONE); end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.fwd_en = 1'b1; bus.exe_mem_read = 1'b1; bus.exe_wb_en = 1'b1;
    bus.exe_dest = 5'd5; bus.id_src1 = 5'd5;
    #1;
    total++;
    if (ctl !== C_HAZ) begin bad++; $display("FAIL load_use ctl=%b exp=%b", ctl, C_HAZ); end
    tick();
    bus.exe_mem_read = 1'b0;
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL load_use_clear ctl=%b exp=%b", ctl, C_NONE); end
    total++;
    if (bus.stall_cnt !== 3'd1) begin bad++; $display("FAIL load_use_cnt got=%0d exp=1", bus.stall_cnt); end
  endtask

  task automatic test_no_forward();
    do_reset();
    bus.fwd_en = 1'b0; bus.mem_wb_en = 1'b1; bus.mem_dest = 5'd7;
    bus.id_src2 = 5'd7; bus.id_two_src = 1'b1; bus.id_src1 = 5'd1;
    #1;
    total++;
    if (ctl !== C_HAZ) begin bad++; $display("FAIL nofwd_src2 ctl=%b exp=%b", ctl, C_HAZ); end
    bus.id_two_src = 1'b0;
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL nofwd_one_src ctl=%b exp=%b", ctl, C_NONE); end
    bus.fwd_en = 1'b1; bus.id_two_src = 1'b1;
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL fwd_mem_hidden ctl=%b exp=%b", ctl, C_NONE); end
    clear_inputs();
    bus.fwd_en = 1'b0; bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd0; bus.id_src1 = 5'd0;
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL nofwd_r0 ctl=%b exp=%b", ctl, C_NONE); end
    bus.exe_dest = 5'd3; bus.id_src1 = 5'd3;
    #1;
    total++;
    if (ctl !== C_HAZ) begin bad++; $display("FAIL nofwd_exe ctl=%b exp=%b", ctl, C_HAZ); end
  endtask

  task automatic test_branch();
    do_reset();
    bus.fwd_en = 1'b1; bus.exe_mem_read = 1'b1; bus.exe_wb_en = 1'b1;
    bus.exe_dest = 5'd9; bus.id_src1 = 5'd9; bus.br_taken = 1'b1;
    #1;
    total++;
    if (ctl !== C_BR) begin bad++; $display("FAIL branch_over_hazard ctl=%b exp=%b", ctl, C_BR); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.br_taken = (i == 1);
      #1;
      total++;
      if (ctl !== C_MEM) begin bad++; $display("FAIL mem_wait_c%0d ctl=%b exp=%b", i, ctl, C_MEM); end
      tick();
    end
    bus.mem_ready = 1'b1; bus.br_taken = 1'b1;
    #1;
    total++;
    if (ctl !== C_BR) begin bad++; $display("FAIL mem_ready_release ctl=%b exp=%b", ctl, C_BR); end
    tick();
    clear_inputs();
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL mem_back_run ctl=%b exp=%b", ctl, C_NONE); end
    total++;
    if (bus.stall_cnt !== 3'd3) begin bad++; $display("FAIL mem_stall_cnt got=%0d exp=3", bus.stall_cnt); end
    total++;
    if (bus.mem_timeout !== 1'b0) begin bad++; $display("FAIL mem_no_timeout got=%b exp=0", bus.mem_timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (bus.mem_timeout !== (k >= 4)) begin
        bad++; $display("FAIL timeout_c%0d got=%b exp=%b", k, bus.mem_timeout, (k >= 4));
      end
    end
    bus.mem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
    total++;
    if (bus.mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", bus.mem_timeout); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_cleared got=%b exp=0", bus.mem_timeout); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    bus.fwd_en = 1'b0; bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd3; bus.id_src1 = 5'd3;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
      if (bus.stall_cnt !== 3'((i > 7) ? 7 : i)) begin
        bad++; $display("FAIL sat_c%0d got=%0d exp=%0d", i, bus.stall_cnt, ((i > 7) ? 7 : i));
      end
    end
    clear_inputs();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    tick();
    tick();
    bus.mem_req = 1'b0;
    #1;
    total++;
    if (ctl !== C_MEM) begin bad++; $display("FAIL in_mem_wait ctl=%b exp=%b", ctl, C_MEM); end
    rst = 1'b0;
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL rst_mid_wait_forced ctl=%b exp=%b", ctl, C_NONE); end
    tick();
    total++;
    if (bus.stall_cnt !== 3'd0) begin bad++; $display("FAIL rst_mid_wait_cnt got=%0d exp=0", bus.stall_cnt); end
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== C_NONE) begin bad++; $display("FAIL rst_mid_wait_run ctl=%b exp=%b", ctl, C_NONE); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_forward();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
